// File: rtl/hpdmc_ddr_wrpath.sv
// DDR write-data path: FIFO-buffered write words sequenced into DQS preamble/data/postamble
// bursts, presented as registered rising/falling (D0/D1) pairs for the ODDR2 output stages.
module hpdmc_ddr_wrpath #(
  parameter int DQ_WIDTH   = 16,
  parameter int BURST_LEN  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    wr_start,
  output logic                    wr_ready,
  input  logic                    wd_stb,
  output logic                    wd_ack,
  input  logic [2*DQ_WIDTH-1:0]   wd_data,
  input  logic [2*DQ_WIDTH/8-1:0] wd_mask,
  output logic [DQ_WIDTH-1:0]     dq_d0,
  output logic [DQ_WIDTH-1:0]     dq_d1,
  output logic [DQ_WIDTH/8-1:0]   dm_d0,
  output logic [DQ_WIDTH/8-1:0]   dm_d1,
  output logic [DQ_WIDTH/8-1:0]   dqs_d0,
  output logic [DQ_WIDTH/8-1:0]   dqs_d1,
  output logic                    dq_oe,
  output logic                    dqs_oe,
  output logic                    busy,
  output logic                    underrun,
  input  logic                    underrun_clr
);

  localparam int NB = DQ_WIDTH / 8;
  localparam int N  = BURST_LEN / 2;
  localparam int BW = (N > 1) ? $clog2(N) : 1;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int WW = 2 * DQ_WIDTH + 2 * NB;

  typedef enum logic [1:0] {IDLE, PRE, DATA, POST} state_t;

  state_t         state, state_nxt;
  logic [BW-1:0]  beat, beat_nxt;
  logic           last_beat;

  logic [WW-1:0]  mem [FIFO_DEPTH];
  logic [AW-1:0]  wr_ptr, rd_ptr;
  logic [CW-1:0]  count;
  logic           full, empty, push, pop, underrun_set;
  logic [WW-1:0]  head;

  // Sequencer control
  assign last_beat = (state == DATA) && (beat == BW'(N - 1));
  assign wr_ready  = (state == IDLE) || last_beat;
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt = state;
    beat_nxt  = beat;
    case (state)
      IDLE: if (wr_start) state_nxt = PRE;
      PRE: begin
        state_nxt = DATA;
        beat_nxt  = '0;
      end
      DATA: begin
        if (last_beat) begin
          // A start on the final beat chains the next burst with no postamble/preamble
          if (wr_start) beat_nxt = '0;
          else          state_nxt = POST;
        end else begin
          beat_nxt = beat + BW'(1);
        end
      end
      POST:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state <= IDLE;
      beat  <= '0;
    end else begin
      state <= state_nxt;
      beat  <= beat_nxt;
    end
  end

  // Write-data FIFO; a full FIFO refuses pushes even when a pop lands on the same edge
  assign full         = (count == CW'(FIFO_DEPTH));
  assign empty        = (count == '0);
  assign wd_ack       = !full;
  assign push         = wd_stb && !full;
  assign pop          = (state_nxt == DATA) && !empty;
  assign underrun_set = (state_nxt == DATA) && empty;
  assign head         = mem[rd_ptr];

  always_ff @(posedge sys_clk) begin
    if (push) mem[wr_ptr] <= {wd_mask, wd_data};
  end

  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      underrun <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
      if (underrun_set)      underrun <= 1'b1;
      else if (underrun_clr) underrun <= 1'b0;
    end
  end

  // Output register stage: loaded from the state being entered so pins track the state
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      dq_d0  <= '0;
      dq_d1  <= '0;
      dm_d0  <= '0;
      dm_d1  <= '0;
      dqs_d0 <= '0;
      dqs_d1 <= '0;
      dq_oe  <= 1'b0;
      dqs_oe <= 1'b0;
    end else begin
      dq_d0  <= '0;
      dq_d1  <= '0;
      dm_d0  <= '0;
      dm_d1  <= '0;
      dqs_d0 <= '0;
      dqs_d1 <= '0;
      dq_oe  <= 1'b0;
      dqs_oe <= 1'b0;
      case (state_nxt)
        PRE, POST: dqs_oe <= 1'b1;
        DATA: begin
          dq_oe  <= 1'b1;
          dqs_oe <= 1'b1;
          dqs_d0 <= '1;
          if (empty) begin
            // Starved beat: mask every byte so the SDRAM ignores it
            dm_d0 <= '1;
            dm_d1 <= '1;
          end else begin
            dq_d0 <= head[DQ_WIDTH-1:0];
            dq_d1 <= head[2*DQ_WIDTH-1:DQ_WIDTH];
            dm_d0 <= head[2*DQ_WIDTH +: NB];
            dm_d1 <= head[2*DQ_WIDTH+NB +: NB];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_hpdmc_ddr_wrpath.sv
// Scoreboard bench for hpdmc_ddr_wrpath (16-bit DQ, burst 4, FIFO depth 4).
module tb_hpdmc_ddr_wrpath;

  logic        sys_clk = 1'b0;
  logic        sys_rst = 1'b1;
  logic        wr_start = 1'b0;
  logic        wr_ready;
  logic        wd_stb = 1'b0;
  logic        wd_ack;
  logic [31:0] wd_data = '0;
  logic [3:0]  wd_mask = '0;
  logic [15:0] dq_d0, dq_d1;
  logic [1:0]  dm_d0, dm_d1, dqs_d0, dqs_d1;
  logic        dq_oe, dqs_oe, busy, underrun;
  logic        underrun_clr = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [40:0] exp_q[$];

  hpdmc_ddr_wrpath #(.DQ_WIDTH(16), .BURST_LEN(4), .FIFO_DEPTH(4)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst), .wr_start(wr_start), .wr_ready(wr_ready),
    .wd_stb(wd_stb), .wd_ack(wd_ack), .wd_data(wd_data), .wd_mask(wd_mask),
    .dq_d0(dq_d0), .dq_d1(dq_d1), .dm_d0(dm_d0), .dm_d1(dm_d1),
    .dqs_d0(dqs_d0), .dqs_d1(dqs_d1), .dq_oe(dq_oe), .dqs_oe(dqs_oe),
    .busy(busy), .underrun(underrun), .underrun_clr(underrun_clr)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Expected pin vector {dq_d0, dq_d1, dm_d0, dm_d1, dqs_d0, dqs_d1, dq_oe}, for dqs_oe=1 cycles
  function automatic logic [40:0] ev_amble();
    return {16'h0, 16'h0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0};
  endfunction
  function automatic logic [40:0] ev_data(input logic [15:0] r, input logic [15:0] f,
                                          input logic [1:0] mr, input logic [1:0] mf);
    return {r, f, mr, mf, 2'b11, 2'b00, 1'b1};
  endfunction
  function automatic logic [40:0] ev_under();
    return {16'h0, 16'h0, 2'b11, 2'b11, 2'b11, 2'b00, 1'b1};
  endfunction

  // Monitor: every cycle with DQS driven must match the next expected vector
  always @(negedge sys_clk) begin
    if (!sys_rst && dqs_oe) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_dqs_cycle", {23'h0, dq_d0, dq_d1, dm_d0, dm_d1, dqs_d0, dqs_d1, dq_oe}, 64'h0);
      end else begin
        chk("beat", {23'h0, dq_d0, dq_d1, dm_d0, dm_d1, dqs_d0, dqs_d1, dq_oe}, {23'h0, exp_q.pop_front()});
      end
    end
  end

  task automatic tick();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic push(input logic [31:0] d, input logic [3:0] m);
    wd_stb  = 1'b1;
    wd_data = d;
    wd_mask = m;
    chk("wd_ack_on_push", wd_ack, 1);
    tick();
    wd_stb  = 1'b0;
    wd_mask = '0;
  endtask

  task automatic start();
    wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
  endtask

  task automatic underrun_burst(input string tag);
    exp_q.push_back(ev_amble());
    exp_q.push_back(ev_under());
    exp_q.push_back(ev_under());
    exp_q.push_back(ev_amble());
    start();
    repeat (4) tick();
    chk({tag, "_busy_done"}, busy, 0);
    chk({tag, "_underrun_set"}, underrun, 1);
    underrun_clr = 1'b1;
    tick();
    underrun_clr = 1'b0;
    chk({tag, "_underrun_clr"}, underrun, 0);
  endtask

  initial begin
    // Reset state
    #2;
    chk("rst_dq_oe", dq_oe, 0);
    chk("rst_dqs_oe", dqs_oe, 0);
    chk("rst_pairs", {dq_d0, dq_d1, dm_d0, dm_d1, dqs_d0, dqs_d1}, 0);
    chk("rst_busy", busy, 0);
    repeat (2) tick();
    sys_rst = 1'b0;
    tick();
    chk("rel_wr_ready", wr_ready, 1);
    chk("rel_wd_ack", wd_ack, 1);
    chk("rel_underrun", underrun, 0);

    // Basic burst with ignored wr_start during POST
    push(32'hBBBB_AAAA, 4'b0000);
    push(32'hDDDD_CCCC, 4'b0000);
    exp_q.push_back(ev_amble());
    exp_q.push_back(ev_data(16'hAAAA, 16'hBBBB, 2'b00, 2'b00));
    exp_q.push_back(ev_data(16'hCCCC, 16'hDDDD, 2'b00, 2'b00));
    exp_q.push_back(ev_amble());
    start();
    chk("pre_dq_oe", dq_oe, 0);
    chk("pre_dqs_oe", dqs_oe, 1);
    repeat (3) tick();
    chk("post_busy", busy, 1);
    chk("post_dq_oe", dq_oe, 0);
    chk("post_wr_ready", wr_ready, 0);
    wr_start = 1'b1;
    tick();
    wr_start = 1'b0;
    chk("idle_busy", busy, 0);

    // Seamless bursts from a full FIFO; push offered while full is refused
    push(32'h1002_1001, 4'b0000);
    push(32'h2002_2001, 4'b0000);
    push(32'h3002_3001, 4'b0000);
    push(32'h4002_4001, 4'b0000);
    chk("full_wd_ack", wd_ack, 0);
    exp_q.push_back(ev_amble());
    exp_q.push_back(ev_data(16'h1001, 16'h1002, 2'b00, 2'b00));
    exp_q.push_back(ev_data(16'h2001, 16'h2002, 2'b00, 2'b00));
    exp_q.push_back(ev_data(16'h3001, 16'h3002, 2'b00, 2'b00));
    exp_q.push_back(ev_data(16'h4001, 16'h4002, 2'b00, 2'b00));
    exp_q.push_back(ev_amble());
    start();
    wd_stb  = 1'b1;
    wd_data = 32'hDEAD_BEEF;
    chk("full_pop_wd_ack", wd_ack, 0);
    tick();
    wd_stb = 1'b0;
    tick();
    chk("last_beat_wr_ready", wr_ready, 1);
    start();
    chk("seamless_dqs_oe", dqs_oe, 1);
    repeat (3) tick();
    chk("seamless_busy_done", busy, 0);

    // Underrun on empty FIFO (also proves the refused word never entered)
    underrun_burst("empty");

    // Byte masks; remaining pushes complete the pointer-wrap sequence
    push(32'h2222_1111, 4'b0110);
    push(32'h4444_3333, 4'b0000);
    exp_q.push_back(ev_amble());
    exp_q.push_back(ev_data(16'h1111, 16'h2222, 2'b10, 2'b01));
    exp_q.push_back(ev_data(16'h3333, 16'h4444, 2'b00, 2'b00));
    exp_q.push_back(ev_amble());
    start();
    repeat (4) tick();
    push(32'h6666_5555, 4'b0000);
    push(32'h8888_7777, 4'b1001);
    exp_q.push_back(ev_amble());
    exp_q.push_back(ev_data(16'h5555, 16'h6666, 2'b00, 2'b00));
    exp_q.push_back(ev_data(16'h7777, 16'h8888, 2'b01, 2'b10));
    exp_q.push_back(ev_amble());
    start();
    repeat (4) tick();
    chk("wrap_underrun", underrun, 0);

    // Asynchronous reset during the second DATA cycle
    push(32'hA2A2_A1A1, 4'b0000);
    push(32'hB2B2_B1B1, 4'b0000);
    push(32'hC2C2_C1C1, 4'b0000);
    push(32'hD2D2_D1D1, 4'b0000);
    exp_q.push_back(ev_amble());
    exp_q.push_back(ev_data(16'hA1A1, 16'hA2A2, 2'b00, 2'b00));
    start();
    tick();
    tick();
    sys_rst = 1'b1;
    #1;
    chk("midrst_dq_oe", dq_oe, 0);
    chk("midrst_dqs_oe", dqs_oe, 0);
    chk("midrst_pairs", {dq_d0, dq_d1, dm_d0, dm_d1, dqs_d0, dqs_d1}, 0);
    chk("midrst_busy", busy, 0);
    tick();
    sys_rst = 1'b0;
    tick();
    chk("midrst_wd_ack", wd_ack, 1);
    chk("midrst_wr_ready", wr_ready, 1);
    chk("midrst_underrun", underrun, 0);
    underrun_burst("after_rst");

    repeat (2) tick();
    chk("queue_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
